// File: rtl/da_vinci_dump_ctrl.sv
// da_vinci_dump_ctrl: runs the processor for a fixed number of cycles (or until
// halt), then takes the shared memory bus and streams out each configured
// address window word by word over a valid/ready port.
module da_vinci_dump_ctrl #(
  parameter int unsigned ADDR_WIDTH = 26,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_WIN    = 2,
  parameter logic [NUM_WIN*ADDR_WIDTH-1:0] WIN_BASE = {26'h3fffff0, 26'h1000000},
  parameter logic [NUM_WIN*16-1:0]         WIN_LEN  = {16'd16, 16'd16},
  parameter int unsigned RUN_CYCLES = 500,
  parameter int unsigned MEM_LAT    = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  HALT,
  output logic                  BUS_REQ,
  input  logic                  BUS_GNT,
  output logic [ADDR_WIDTH-1:0] ADDR,
  output logic                  READ,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  output logic                  DUMP_VALID,
  input  logic                  DUMP_READY,
  output logic [DATA_WIDTH-1:0] DUMP_DATA,
  output logic [ADDR_WIDTH-1:0] DUMP_ADDR,
  output logic [2:0]            DUMP_WIN,
  output logic                  DONE
);

  localparam int unsigned RCW = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
  localparam int unsigned LW  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [2:0] {st_run, st_req, st_rd, st_out, st_fin} state_t;

  state_t          state;
  logic [RCW-1:0]  run_cnt;
  logic [LW-1:0]   lat;
  logic [2:0]      win;
  logic [15:0]     offset;
  logic            none;

  logic [3:0]            first;
  logic [3:0]            nxt;
  logic                  last_word;
  logic [2:0]            adv_win;
  logic [15:0]           adv_off;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH-1:0] adv_addr;

  function automatic logic [ADDR_WIDTH-1:0] base_of(input logic [2:0] w);
    return WIN_BASE[32'(w)*ADDR_WIDTH +: ADDR_WIDTH];
  endfunction

  function automatic logic [15:0] len_of(input logic [2:0] w);
    return WIN_LEN[32'(w)*16 +: 16];
  endfunction

  // Lowest non-empty window at or above start; bit 3 flags that one exists.
  // Scanning downwards lets the lowest match overwrite higher ones.
  function automatic logic [3:0] find_win(input logic [3:0] start);
    logic [3:0]  r;
    int unsigned i;
    r = '0;
    for (int unsigned j = 0; j < NUM_WIN; j++) begin
      i = NUM_WIN - 1 - j;
      if (i >= 32'(start) && WIN_LEN[i*16 +: 16] != '0)
        r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  // Window/offset sequencing and address arithmetic (wraps modulo 2^ADDR_WIDTH).
  always_comb begin
    first     = find_win(4'd0);
    nxt       = find_win({1'b0, win} + 4'd1);
    last_word = ({1'b0, offset} + 17'd1) == {1'b0, len_of(win)};
    adv_win   = last_word ? nxt[2:0] : win;
    adv_off   = last_word ? '0 : offset + 16'd1;
    rd_addr   = base_of(win) + ADDR_WIDTH'(offset);
    adv_addr  = base_of(adv_win) + ADDR_WIDTH'(adv_off);
  end

  // Control FSM with registered bus and dump-port outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= st_run;
      run_cnt    <= '0;
      lat        <= '0;
      win        <= '0;
      offset     <= '0;
      none       <= 1'b0;
      BUS_REQ    <= 1'b0;
      ADDR       <= '0;
      READ       <= 1'b0;
      DUMP_VALID <= 1'b0;
      DUMP_DATA  <= '0;
      DUMP_ADDR  <= '0;
      DUMP_WIN   <= '0;
      DONE       <= 1'b0;
    end else begin
      case (state)
        st_run: begin
          if (HALT || run_cnt == RCW'(RUN_CYCLES - 1)) begin
            state   <= st_req;
            BUS_REQ <= 1'b1;
            win     <= first[2:0];
            offset  <= '0;
            none    <= ~first[3];
          end else begin
            run_cnt <= run_cnt + RCW'(1);
          end
        end
        st_req: begin
          if (none) begin
            state   <= st_fin;
            BUS_REQ <= 1'b0;
            DONE    <= 1'b1;
          end else if (BUS_GNT) begin
            state <= st_rd;
            READ  <= 1'b1;
            ADDR  <= rd_addr;
            lat   <= '0;
          end
        end
        st_rd: begin
          // Losing the grant abandons this read; win/offset are untouched so
          // the same word is fetched again from the start once re-granted.
          if (!BUS_GNT) begin
            state <= st_req;
            READ  <= 1'b0;
            ADDR  <= '0;
          end else if (lat == LW'(MEM_LAT - 1)) begin
            state      <= st_out;
            READ       <= 1'b0;
            ADDR       <= '0;
            DUMP_DATA  <= DATA_IN;
            DUMP_ADDR  <= ADDR;
            DUMP_WIN   <= win;
            DUMP_VALID <= 1'b1;
          end else begin
            lat <= lat + LW'(1);
          end
        end
        st_out: begin
          if (DUMP_READY) begin
            DUMP_VALID <= 1'b0;
            if (last_word && !nxt[3]) begin
              state   <= st_fin;
              BUS_REQ <= 1'b0;
              DONE    <= 1'b1;
            end else begin
              win    <= adv_win;
              offset <= adv_off;
              if (BUS_GNT) begin
                state <= st_rd;
                READ  <= 1'b1;
                ADDR  <= adv_addr;
                lat   <= '0;
              end else begin
                state <= st_req;
              end
            end
          end
        end
        st_fin: begin
        end
        default: state <= st_run;
      endcase
    end
  end

endmodule

// File: doc/da_vinci_dump_ctrl.md
# da_vinci_dump_ctrl

Synthesizable memory-dump controller for the DA_VINCI system. It runs the processor for a programmable number of cycles, or until halt. It then takes the memory bus and reads out up to NUM_WIN address windows, streaming each word over a valid/ready port. This lets a bench or an on-chip debug path capture result regions without hierarchical access to the SRAM array. It sits beside the processor on the shared memory bus (ADDR/READ/DATA) and arbitrates through a request/grant pair.

## Interface
- ADDR_WIDTH, 26: memory address width.
- DATA_WIDTH, 32: memory data width.
- NUM_WIN, 2: number of dump windows (1..8).
- WIN_BASE, {26'h3fffff0, 26'h1000000}: packed NUM_WIN*ADDR_WIDTH base addresses; window 0 in the LSBs.
- WIN_LEN, {16'd16, 16'd16}: packed NUM_WIN*16 word counts; 0 means skip the window.
- RUN_CYCLES, 500: cycles to run after reset before dumping (>=1).
- MEM_LAT, 2: cycles READ is held before DATA_IN is sampled (>=1).

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- HALT  in  1  processor halt; starts an early dump.
- BUS_REQ  out  1  request for the memory bus.
- BUS_GNT  in  1  bus granted to this block.
- ADDR  out  ADDR_WIDTH  read address; 0 when not reading.
- READ  out  1  memory read strobe.
- DATA_IN  in  DATA_WIDTH  memory read data.
- DUMP_VALID  out  1  dump word available.
- DUMP_READY  in  1  consumer accepts the word.
- DUMP_DATA  out  DATA_WIDTH  dumped word.
- DUMP_ADDR  out  ADDR_WIDTH  address of the dumped word.
- DUMP_WIN  out  3  window index of the dumped word.
- DONE  out  1  sticky; all windows dumped.

## Operation
- States:
  - RUN: the run counter counts up each cycle. Go to REQ when the count equals RUN_CYCLES-1, or when HALT=1 is sampled, whichever comes first.
  - REQ: BUS_REQ=1. On BUS_GNT=1, go to RD with the current window/word. On entry from RUN, go first to the first non-empty window. If no window is non-empty, go straight to FIN.
  - RD: ADDR=base+offset, READ=1 for exactly MEM_LAT cycles. In the last RD cycle, DATA_IN is registered into DUMP_DATA, then go to OUT.
  - OUT: DUMP_VALID=1, with DUMP_DATA/DUMP_ADDR/DUMP_WIN held stable until DUMP_READY=1. On handshake, advance the offset. At the end of a window, advance to the next non-empty window. After the last window, go to FIN; otherwise return to RD.
  - FIN: BUS_REQ=0 and DONE=1, held until RST.
- Address arithmetic: base+offset is modulo 2^ADDR_WIDTH. A window crossing the top of memory wraps to 0. The offset counter is 16 bits.
- BUS_GNT is sampled every cycle in RD. If it falls, READ drops that cycle and the FSM returns to REQ. The interrupted word is re-read from the start of RD; no word is skipped or duplicated.
- BUS_GNT falling during OUT does not abort the handshake. The next RD waits in REQ for the grant.
- HALT is ignored outside RUN.
- RST in any state, including mid-dump: next cycle state=RUN, all counters 0, all outputs 0.

## Timing
- Reset values: BUS_REQ=0, ADDR=0, READ=0, DUMP_VALID=0, DUMP_DATA=0, DUMP_ADDR=0, DUMP_WIN=0, DONE=0.
- With RST released at cycle 0 and no HALT, BUS_REQ rises at cycle RUN_CYCLES.
- HALT sampled high at cycle k: BUS_REQ=1 at k+1.
- Grant sampled at cycle g: READ=1 for cycles g+1..g+MEM_LAT, and DUMP_VALID=1 from g+MEM_LAT+1.
- Per-word throughput with DUMP_READY tied high: MEM_LAT+1 cycles.
- The handshake completes in the cycle where DUMP_VALID and DUMP_READY are both 1. DUMP_VALID never drops without a handshake, except on RST.
- DONE rises one cycle after the final handshake. BUS_REQ falls in the same cycle.

## Test plan
- Default parameters, GNT tied 1, READY tied 1, memory returns data=addr: 32 words. Window 0 covers 0x1000000..0x100000F, then window 1 covers 0x3FFFFF0..0x3FFFFFF. DONE at cycle 500+1+32*3.
- RUN_CYCLES=500, HALT pulsed at cycle 40: BUS_REQ=1 at cycle 41. A HALT pulse after the dump starts has no effect.
- WIN_LEN={16'd0, 16'd4}: only window 0 is dumped. With both lengths 0: no READ, DONE one cycle after grant path entry.
- Window base 0x3FFFFFE, length 4: dumped addresses are 0x3FFFFFE, 0x3FFFFFF, 0x0000000, 0x0000001.
- DUMP_READY held low for 10 cycles on word 3: outputs stay stable; word 4 follows only after acceptance. Separately, drop GNT mid-RD on word 5: word 5 is re-read and emitted once.
- Assert RST during the OUT of window 1 word 2: next cycle all outputs are 0 and state is RUN. A full dump repeats from window 0 word 0 after RUN_CYCLES.
